mu0_phase_sequencer: RTL
========================

Name: mu0_phase_sequencer

Overview:
- Control sequencer for the MU0 datapath. It generates the one-hot FETCH/EXEC1/EXEC2 phase strobes consumed by the instruction decoder.
- Phase length is chosen per opcode. FETCH and memory-accessing EXEC1 phases are held while memory is not ready.
- Stops the core on STP, undefined opcodes or a memory timeout. Counts retired instructions for debug and performance.

Parameters:
- CNT_W, 16, width of INSTR_COUNT.
- MAX_WAIT, 15, maximum number of consecutive stall cycles in one phase before a bus error; legal range 1..255.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- RUN  in  1  level; 1 = execute, 0 = stop at the next instruction boundary.
- CONTINUE  in  1  one-cycle pulse; resumes from HALTED and clears BUS_ERR/ILLEGAL.
- OP  in  4  opcode from the IR (OP[15:12]); valid in EXEC1 and EXEC2.
- MEM_READY  in  1  memory handshake; 1 = the current access completes this cycle.
- FETCH  out  1  fetch phase strobe.
- EXEC1  out  1  execute-1 phase strobe.
- EXEC2  out  1  execute-2 phase strobe.
- STALL  out  1  current phase is held; datapath register enables are gated by ~STALL.
- HALTED  out  1  core stopped (STP, illegal opcode or bus error).
- ILLEGAL  out  1  sticky flag: undefined opcode executed.
- BUS_ERR  out  1  sticky flag: memory wait timeout.
- INSTR_COUNT  out  CNT_W  retired instruction count.

Behaviour:
- States: IDLE, S_FETCH, S_EXEC1, S_EXEC2, S_HALT. Register the state; decode the strobes from it. At most one of FETCH/EXEC1/EXEC2 is high in any cycle.
- Reset (asynchronous, takes effect immediately, also mid-instruction):
  - state = IDLE.
  - All outputs 0, INSTR_COUNT = 0, wait counter = 0.
- IDLE: no strobe is high. RUN=1 -> S_FETCH on the next cycle.
- S_FETCH:
  - Memory access phase. STALL = ~MEM_READY.
  - MEM_READY=1 -> S_EXEC1.
- S_EXEC1, next state by OP:
  - 0 (LDA), 2 (ADD), 3 (SUB): memory access. STALL = ~MEM_READY. On MEM_READY=1 -> S_EXEC2.
  - 1 (STA): memory access. STALL = ~MEM_READY. On MEM_READY=1 -> retire.
  - 4, 5, 6, 8, 9, A, B: no memory access, STALL = 0 -> retire.
  - 7 (STP): -> S_HALT and retire (INSTR_COUNT increments).
  - C to F: -> S_HALT with ILLEGAL = 1. Not retired.
- S_EXEC2: STALL = 0 -> retire.
- Retire: INSTR_COUNT increments by 1 and wraps modulo 2^CNT_W. Next state is S_FETCH if RUN=1, otherwise IDLE. RUN is sampled only at the retire cycle, so RUN=0 never aborts a started instruction.
- Wait counter:
  - Clears on every phase transition. Increments each cycle that STALL=1.
  - If STALL=1 and the counter equals MAX_WAIT: next state S_HALT, BUS_ERR = 1, no retire.
  - MEM_READY=1 in that same cycle takes priority; the access completes normally.
- S_HALT:
  - HALTED = 1, no strobe high.
  - CONTINUE=1 clears ILLEGAL and BUS_ERR. Next state is S_FETCH if RUN=1, otherwise IDLE.
  - The PC is not touched here; the resumed fetch uses the PC the decoder left.
- CONTINUE outside S_HALT is ignored.
- MEM_READY is ignored in IDLE, S_HALT, S_EXEC2 and non-memory EXEC1 phases.
- Latency: every transition takes one cycle.
  - 2-cycle instructions: FETCH, EXEC1 (JMP/JMI/JEQ/STA/LDI/shifts).
  - 3-cycle instructions: FETCH, EXEC1, EXEC2 (LDA/ADD/SUB).
  - Each memory stall cycle adds 1.

Optional Feature:
- Macro: MU0_SINGLE_STEP_EN.
- When defined, two extra input ports exist:
  - SSTEP (1 bit, level): enables single-step mode.
  - STEP (1 bit, pulse): releases one instruction.
- With SSTEP=1, every retire goes to IDLE regardless of RUN. In IDLE, STEP=1 -> S_FETCH, and RUN is not required. With SSTEP=0, behaviour is identical to the build without the macro.
- When not defined, the ports are absent and the sequencer behaves as with SSTEP=0.

Test Plan:
- Reset, RUN=1, MEM_READY=1, OP sequence 8 (LDI), 0 (LDA), 7 (STP) -> strobes F,E1, F,E1,E2, F,E1, then HALTED=1. INSTR_COUNT = 3. Total 7 active cycles.
- OP=2 (ADD), MEM_READY low for 3 cycles in FETCH and 2 cycles in EXEC1 -> STALL high for exactly those 5 cycles. No strobe change while stalled. EXEC2 follows. INSTR_COUNT += 1.
- MEM_READY held 0 in FETCH with MAX_WAIT=15 -> after 16 FETCH cycles the state is S_HALT with BUS_ERR=1 and INSTR_COUNT unchanged. CONTINUE with RUN=1 -> BUS_ERR=0 and FETCH high on the next cycle.
- OP=4'hD -> HALTED=1, ILLEGAL=1, count unchanged. Reassert RST_N low mid-EXEC2 of a later ADD -> all outputs 0 immediately, before any clock edge.
- RUN dropped during EXEC1 of LDA -> EXEC2 still occurs, then IDLE. With CNT_W=4 and INSTR_COUNT=15, that retire -> INSTR_COUNT=0.
- (MU0_SINGLE_STEP_EN) SSTEP=1, STEP pulses 2 times with OP=9 -> exactly 2 FETCH/EXEC1 pairs, IDLE in between, INSTR_COUNT=2.

Source files
------------

// File: rtl/mu0_phase_sequencer.sv
// MU0 control sequencer: one-hot FETCH/EXEC1/EXEC2 strobes, memory stalls, halt and retire count.
// Optional single-step ports (sstep, step) exist when MU0_SINGLE_STEP_EN is defined.
module mu0_phase_sequencer #(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             cont,
   input  logic [3:0]       op,
   input  logic             mem_ready,
`ifdef MU0_SINGLE_STEP_EN
   input  logic             sstep,
   input  logic             step,
`endif
   output logic             fetch,
   output logic             exec1,
   output logic             exec2,
   output logic             stall,
   output logic             halted,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {StIdle, StFetch, StExec1, StExec2, StHalt} state_e;

   localparam logic [7:0]       MaxWait = 8'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   state_e     state_q;
   logic [7:0] wait_q;
   logic       mem_phase;
   logic       ss_mode;
   logic       ss_go;
   state_e     retire_state;

`ifdef MU0_SINGLE_STEP_EN
   assign ss_mode = sstep;
   assign ss_go   = step;
`else
   assign ss_mode = 1'b0;
   assign ss_go   = 1'b0;
`endif

   // LDA/STA/ADD/SUB (op 0..3) access memory in EXEC1
   assign mem_phase = (state_q == StFetch) || ((state_q == StExec1) && (op[3:2] == 2'b00));
   assign stall     = mem_phase && !mem_ready;

   assign fetch  = (state_q == StFetch);
   assign exec1  = (state_q == StExec1);
   assign exec2  = (state_q == StExec2);
   assign halted = (state_q == StHalt);

   assign retire_state = (run && !ss_mode) ? StFetch : StIdle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         wait_q      <= 8'd0;
         instr_count <= '0;
         illegal     <= 1'b0;
         bus_err     <= 1'b0;
      end else begin
         wait_q <= 8'd0;
         if (stall) begin
            if (wait_q == MaxWait) begin
               state_q <= StHalt;
               bus_err <= 1'b1;
            end else begin
               wait_q <= wait_q + 8'd1;
            end
         end else begin
            case (state_q)
               StIdle: begin
                  if (ss_mode ? ss_go : run) state_q <= StFetch;
               end
               StFetch: state_q <= StExec1;
               StExec1: begin
                  case (op)
                     4'h0, 4'h2, 4'h3: state_q <= StExec2;
                     4'h7: begin
                        state_q     <= StHalt;
                        instr_count <= instr_count + CntOne;
                     end
                     4'hC, 4'hD, 4'hE, 4'hF: begin
                        state_q <= StHalt;
                        illegal <= 1'b1;
                     end
                     default: begin
                        state_q     <= retire_state;
                        instr_count <= instr_count + CntOne;
                     end
                  endcase
               end
               StExec2: begin
                  state_q     <= retire_state;
                  instr_count <= instr_count + CntOne;
               end
               StHalt: begin
                  if (cont) begin
                     illegal <= 1'b0;
                     bus_err <= 1'b0;
                     state_q <= run ? StFetch : StIdle;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule
